// File: rtl/tlink_mem_responder.sv
// TileLink manager-side memory responder: serves uncached Acquires from a local SRAM and
// tracks each granted master transaction ID until the client retires it with a Finish.
module tlink_mem_responder #(
   parameter int unsigned LN_ENDPOINTS = 2,
   parameter int unsigned MY_ENDPOINT  = 1,
   parameter int unsigned ADDR_BITS    = 26,
   parameter int unsigned CXID_BITS    = 2,
   parameter int unsigned MXID_BITS    = 2,
   parameter int unsigned DATA_BITS    = 128,
   parameter int unsigned MASK_BITS    = 16,
   parameter int unsigned MEM_WORDS    = 1024
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    acq_valid,
   output logic                    acq_ready,
   input  logic [LN_ENDPOINTS-1:0] acq_src,
   input  logic [LN_ENDPOINTS-1:0] acq_dst,
   input  logic [ADDR_BITS-1:0]    acq_addr,
   input  logic [CXID_BITS-1:0]    acq_client_xact_id,
   input  logic [DATA_BITS-1:0]    acq_data,
   input  logic                    acq_uncached,
   input  logic [2:0]              acq_a_type,
   input  logic [MASK_BITS-1:0]    acq_write_mask,
   output logic                    gnt_valid,
   input  logic                    gnt_ready,
   output logic [LN_ENDPOINTS-1:0] gnt_src,
   output logic [LN_ENDPOINTS-1:0] gnt_dst,
   output logic [CXID_BITS-1:0]    gnt_client_xact_id,
   output logic [MXID_BITS-1:0]    gnt_master_xact_id,
   output logic [DATA_BITS-1:0]    gnt_data,
   output logic [3:0]              gnt_g_type,
   input  logic                    fin_valid,
   output logic                    fin_ready,
   input  logic [MXID_BITS-1:0]    fin_master_xact_id,
   output logic [2**MXID_BITS-1:0] pending,
   output logic                    err_finish
);

   localparam int unsigned NUM_TRK  = 2**MXID_BITS;
   localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MEM   = 2'd1;
   localparam logic [1:0] GRANT = 2'd2;

   localparam logic [2:0] A_READ  = 3'd2;
   localparam logic [2:0] A_WRITE = 3'd3;

   localparam logic [3:0] G_READ_ACK  = 4'd3;
   localparam logic [3:0] G_WRITE_ACK = 4'd4;
   localparam logic [3:0] G_ERROR     = 4'd7;

   localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(MEM_WORDS);

   logic [1:0]              state_q, state_d;
   logic [NUM_TRK-1:0]      pending_q, pending_d;
   logic [MXID_BITS-1:0]    mxid_q;
   logic [LN_ENDPOINTS-1:0] src_q;
   logic [CXID_BITS-1:0]    cxid_q;
   logic [ADDR_BITS-1:0]    addr_q;
   logic [2:0]              a_type_q;
   logic                    uncached_q;
   logic [DATA_BITS-1:0]    data_q;
   logic [MASK_BITS-1:0]    mask_q;
   logic [3:0]              g_type_q;
   logic [DATA_BITS-1:0]    rdata_q;
   logic                    err_finish_q;

   logic [DATA_BITS-1:0]    mem [MEM_WORDS];

   logic [MXID_BITS-1:0]    free_id;
   logic                    acq_fire;
   logic                    gnt_fire;
   logic                    req_err;
   logic [IDX_BITS-1:0]     mem_idx;
   logic                    unused_dst;

   assign unused_dst = ^acq_dst;

   // Only pending_q counts in IDLE: the in-flight tracker has already been granted
   // (and marked pending) by the time the FSM returns here.
   always_comb begin
      free_id = '0;
      for (int i = NUM_TRK - 1; i >= 0; i--) begin
         if (!pending_q[i]) free_id = MXID_BITS'(i);
      end
   end

   assign acq_ready = (state_q == IDLE) && (|(~pending_q));
   assign acq_fire  = acq_valid && acq_ready;
   assign gnt_valid = (state_q == GRANT);
   assign gnt_fire  = gnt_valid && gnt_ready;

   assign req_err = !uncached_q || !((a_type_q == A_READ) || (a_type_q == A_WRITE)) ||
                    (addr_q >= ADDR_LIMIT);
   assign mem_idx = addr_q[IDX_BITS-1:0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (acq_fire) state_d = MEM;
         MEM:     state_d = GRANT;
         GRANT:   if (gnt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A Finish looks only at registered pending, so one racing its own grant is an error.
   always_comb begin
      pending_d = pending_q;
      if (fin_valid && pending_q[fin_master_xact_id]) pending_d[fin_master_xact_id] = 1'b0;
      if (gnt_fire) pending_d[mxid_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         mxid_q       <= '0;
         src_q        <= '0;
         cxid_q       <= '0;
         addr_q       <= '0;
         a_type_q     <= '0;
         uncached_q   <= 1'b0;
         data_q       <= '0;
         mask_q       <= '0;
         g_type_q     <= '0;
         err_finish_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         err_finish_q <= fin_valid && !pending_q[fin_master_xact_id];
         if (acq_fire) begin
            mxid_q     <= free_id;
            src_q      <= acq_src;
            cxid_q     <= acq_client_xact_id;
            addr_q     <= acq_addr;
            a_type_q   <= acq_a_type;
            uncached_q <= acq_uncached;
            data_q     <= acq_data;
            mask_q     <= acq_write_mask;
         end
         if (state_q == MEM) begin
            if (req_err)                 g_type_q <= G_ERROR;
            else if (a_type_q == A_READ) g_type_q <= G_READ_ACK;
            else                         g_type_q <= G_WRITE_ACK;
         end
      end
   end

   // SRAM array and read register carry no reset.
   always_ff @(posedge clk) begin
      if ((state_q == MEM) && !req_err) begin
         if (a_type_q == A_WRITE) begin
            for (int b = 0; b < MASK_BITS; b++) begin
               if (mask_q[b]) mem[mem_idx][8*b +: 8] <= data_q[8*b +: 8];
            end
         end else begin
            rdata_q <= mem[mem_idx];
         end
      end
   end

   assign gnt_src            = LN_ENDPOINTS'(MY_ENDPOINT);
   assign gnt_dst            = src_q;
   assign gnt_client_xact_id = cxid_q;
   assign gnt_master_xact_id = mxid_q;
   assign gnt_g_type         = g_type_q;
   assign gnt_data           = (g_type_q == G_READ_ACK) ? rdata_q : '0;
   assign fin_ready          = 1'b1;
   assign pending            = pending_q;
   assign err_finish         = err_finish_q;

endmodule

// File: tb/tb_tlink_mem_responder.sv
// Scoreboard bench for tlink_mem_responder: expected grants are queued at issue time and
// a negedge monitor checks every grant handshake against the queue head.
module tb_tlink_mem_responder;

   typedef struct packed {
      logic [1:0]   dst;
      logic [1:0]   cx;
      logic [1:0]   mx;
      logic [3:0]   gt;
      logic [127:0] data;
   } exp_t;

   localparam logic [127:0] D1     = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] D2     = 128'hDEADBEEFCAFEF00D0F1E2D3C4B5A6978;
   localparam logic [127:0] ONES   = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [127:0] ONES_L = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00;

   logic         clk = 1'b0;
   logic         rstn;
   logic         acq_valid;
   logic         acq_ready;
   logic [1:0]   acq_src, acq_dst;
   logic [25:0]  acq_addr;
   logic [1:0]   acq_client_xact_id;
   logic [127:0] acq_data;
   logic         acq_uncached;
   logic [2:0]   acq_a_type;
   logic [15:0]  acq_write_mask;
   logic         gnt_valid, gnt_ready;
   logic [1:0]   gnt_src, gnt_dst, gnt_client_xact_id, gnt_master_xact_id;
   logic [127:0] gnt_data;
   logic [3:0]   gnt_g_type;
   logic         fin_valid, fin_ready;
   logic [1:0]   fin_master_xact_id;
   logic [3:0]   pending;
   logic         err_finish;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   tlink_mem_responder dut (
      .clk                (clk),
      .rstn               (rstn),
      .acq_valid          (acq_valid),
      .acq_ready          (acq_ready),
      .acq_src            (acq_src),
      .acq_dst            (acq_dst),
      .acq_addr           (acq_addr),
      .acq_client_xact_id (acq_client_xact_id),
      .acq_data           (acq_data),
      .acq_uncached       (acq_uncached),
      .acq_a_type         (acq_a_type),
      .acq_write_mask     (acq_write_mask),
      .gnt_valid          (gnt_valid),
      .gnt_ready          (gnt_ready),
      .gnt_src            (gnt_src),
      .gnt_dst            (gnt_dst),
      .gnt_client_xact_id (gnt_client_xact_id),
      .gnt_master_xact_id (gnt_master_xact_id),
      .gnt_data           (gnt_data),
      .gnt_g_type         (gnt_g_type),
      .fin_valid          (fin_valid),
      .fin_ready          (fin_ready),
      .fin_master_xact_id (fin_master_xact_id),
      .pending            (pending),
      .err_finish         (err_finish)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && gnt_valid && gnt_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_grant", 144'(gnt_g_type), 144'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant", {gnt_dst, gnt_client_xact_id, gnt_master_xact_id, gnt_g_type, gnt_data},
                  e);
            check("gnt_src", 144'(gnt_src), 144'(1));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] t, input logic unc, input logic [25:0] a,
                       input logic [127:0] d, input logic [15:0] m, input logic [1:0] cx,
                       input logic [1:0] src, input logic [1:0] emx, input logic [3:0] egt,
                       input logic [127:0] edata);
      int   n = 0;
      exp_t e;
      while (!acq_ready && n < 60) begin
         step();
         n++;
      end
      check("acq_ready_wait", 144'(acq_ready), 144'(1));
      e.dst = src; e.cx = cx; e.mx = emx; e.gt = egt; e.data = edata;
      exp_q.push_back(e);
      acq_a_type = t; acq_uncached = unc; acq_addr = a; acq_data = d;
      acq_write_mask = m; acq_client_xact_id = cx; acq_src = src; acq_valid = 1'b1;
      step();
      acq_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("grant_wait", 144'(exp_q.size()), 144'(0));
      step();
   endtask

   task automatic fin(input logic [1:0] id);
      fin_master_xact_id = id;
      fin_valid = 1'b1;
      step();
      fin_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; acq_valid = 1'b0; acq_src = 2'd0; acq_dst = 2'd1; acq_addr = '0;
      acq_client_xact_id = '0; acq_data = '0; acq_uncached = 1'b1; acq_a_type = 3'd0;
      acq_write_mask = '0; gnt_ready = 1'b1; fin_valid = 1'b0; fin_master_xact_id = '0;
      repeat (3) step();
      check("rst_gnt_valid", 144'(gnt_valid), 144'(0));
      check("rst_pending", 144'(pending), 144'(0));
      check("rst_err_finish", 144'(err_finish), 144'(0));
      check("rst_fin_ready", 144'(fin_ready), 144'(1));
      check("rst_gnt_fields", {gnt_g_type, gnt_master_xact_id, gnt_client_xact_id, gnt_data},
            144'(0));
      rstn = 1'b1;
      step();
      check("rst_acq_ready", 144'(acq_ready), 144'(1));

      // Write then read with latency check
      send(3'd3, 1'b1, 26'd5, D1, 16'hFFFF, 2'd1, 2'd2, 2'd0, 4'd4, '0);
      check("lat_mem_cycle", 144'(gnt_valid), 144'(0));
      step();
      check("lat_grant_cycle", 144'(gnt_valid), 144'(1));
      wait_idle();
      check("pending_after_write", 144'(pending), 144'(4'b0001));
      fin(2'd0);
      check("pending_after_fin", 144'(pending), 144'(0));
      check("no_err_finish", 144'(err_finish), 144'(0));
      send(3'd2, 1'b1, 26'd5, '0, 16'h0, 2'd2, 2'd3, 2'd0, 4'd3, D1);
      wait_idle();
      fin(2'd0);

      // Byte mask
      send(3'd3, 1'b1, 26'd7, ONES, 16'hFFFF, 2'd0, 2'd1, 2'd0, 4'd4, '0);
      wait_idle(); fin(2'd0);
      send(3'd3, 1'b1, 26'd7, '0, 16'h0001, 2'd0, 2'd1, 2'd0, 4'd4, '0);
      wait_idle(); fin(2'd0);
      send(3'd2, 1'b1, 26'd7, '0, 16'h0, 2'd0, 2'd1, 2'd0, 4'd3, ONES_L);
      wait_idle(); fin(2'd0);

      // Tracker exhaustion
      for (int i = 0; i < 4; i++) begin
         send(3'd2, 1'b1, 26'd5, '0, 16'h0, 2'(i), 2'd1, 2'(i), 4'd3, D1);
      end
      wait_idle();
      check("pending_full", 144'(pending), 144'(4'hF));
      check("full_acq_ready", 144'(acq_ready), 144'(0));
      step(); step();
      check("full_acq_ready_hold", 144'(acq_ready), 144'(0));
      fin(2'd2);
      check("pending_after_fin2", 144'(pending), 144'(4'b1011));
      check("acq_ready_after_fin2", 144'(acq_ready), 144'(1));
      send(3'd2, 1'b1, 26'd5, '0, 16'h0, 2'd3, 2'd0, 2'd2, 4'd3, D1);
      wait_idle();
      for (int i = 0; i < 4; i++) fin(2'(i));
      check("pending_drained", 144'(pending), 144'(0));

      // Errors
      send(3'd0, 1'b1, 26'd5, D2, 16'hFFFF, 2'd1, 2'd1, 2'd0, 4'd7, '0);
      wait_idle(); fin(2'd0);
      send(3'd2, 1'b0, 26'd5, '0, 16'h0, 2'd1, 2'd1, 2'd0, 4'd7, '0);
      wait_idle(); fin(2'd0);
      send(3'd3, 1'b1, 26'd0, D2, 16'hFFFF, 2'd0, 2'd1, 2'd0, 4'd4, '0);
      wait_idle(); fin(2'd0);
      send(3'd3, 1'b1, 26'd1024, '0, 16'hFFFF, 2'd2, 2'd1, 2'd0, 4'd7, '0);
      wait_idle(); fin(2'd0);
      send(3'd2, 1'b1, 26'd0, '0, 16'h0, 2'd2, 2'd1, 2'd0, 4'd3, D2);
      wait_idle(); fin(2'd0);
      fin(2'd3);
      check("err_finish_pulse", 144'(err_finish), 144'(1));
      check("err_finish_pending", 144'(pending), 144'(0));
      step();
      check("err_finish_clear", 144'(err_finish), 144'(0));

      // Back-pressure with a competing acquire held high
      gnt_ready = 1'b0;
      send(3'd3, 1'b1, 26'd9, D2, 16'hFFFF, 2'd3, 2'd1, 2'd0, 4'd4, '0);
      acq_valid = 1'b1; acq_a_type = 3'd2; acq_addr = 26'd9; acq_client_xact_id = 2'd2;
      step();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 144'(gnt_valid), 144'(1));
         check("bp_payload", {gnt_g_type, gnt_master_xact_id, gnt_client_xact_id, gnt_data},
               {4'd4, 2'd0, 2'd3, 128'd0});
         check("bp_acq_ready", 144'(acq_ready), 144'(0));
         step();
      end
      acq_valid = 1'b0;
      gnt_ready = 1'b1;
      wait_idle();
      check("bp_pending", 144'(pending), 144'(4'b0001));

      // Reset during GRANT with tracker 0 still pending
      gnt_ready = 1'b0;
      send(3'd2, 1'b1, 26'd5, '0, 16'h0, 2'd1, 2'd1, 2'd1, 4'd3, D1);
      step();
      check("pre_reset_valid", 144'(gnt_valid), 144'(1));
      rstn = 1'b0;
      #1;
      check("reset_gnt_valid", 144'(gnt_valid), 144'(0));
      check("reset_pending", 144'(pending), 144'(0));
      void'(exp_q.pop_back());
      step();
      rstn = 1'b1;
      gnt_ready = 1'b1;
      send(3'd2, 1'b1, 26'd9, '0, 16'h0, 2'd2, 2'd1, 2'd0, 4'd3, D2);
      wait_idle();
      fin(2'd0);

      check("queue_empty", 144'(exp_q.size()), 144'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
